instr_fetch_reg: RTL and testbench
==================================

Name: instr_fetch_reg

Overview:
- Fetch stage directly upstream of the 9-bit sign-extension stage.
- Holds the program counter and requests 16-bit instruction words from instruction memory over a req/ack handshake.
- Latches each returned word and splits it into a 7-bit opcode and a 9-bit immediate. The immediate feeds the sign extender's data_in.
- Supports back-pressure via stall, and PC redirection via branch_en.

Parameters:
- ADDR_W, 10, PC / memory address width; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  leave IDLE and begin fetching.
- stall  in  1  downstream not ready; hold current instruction.
- branch_en  in  1  redirect PC; takes priority over normal sequencing.
- branch_target  in  ADDR_W  new PC when branch_en=1.
- mem_req  out  1  fetch request, registered.
- mem_addr  out  ADDR_W  fetch address (= pc while mem_req=1).
- mem_ack  in  1  memory returns mem_rdata this cycle.
- mem_rdata  in  16  instruction word.
- instr_valid  out  1  instr/opcode/imm9 hold a live instruction.
- instr  out  16  latched instruction word.
- opcode  out  7  instr[15:9].
- imm9  out  9  instr[8:0], to sign-extension stage.
- pc  out  ADDR_W  address of the next fetch.
- busy  out  1  state != IDLE.
- halted  out  1  halt detected (optional feature; 0 otherwise).

Behaviour:
- Reset (rst_n=0, async, effective immediately, also mid-operation):
  - state=IDLE, pc=RESET_PC.
  - mem_req=0, instr_valid=0, instr=0, busy=0, halted=0.
  - Any outstanding fetch is abandoned; an ack arriving after reset release is ignored in IDLE.
- States: IDLE, REQ, ISSUE (+HALTED with the optional feature).
- IDLE:
  - start=1 -> REQ.
  - branch_en in IDLE loads pc and stays in IDLE.
- REQ:
  - mem_req=1, mem_addr=pc.
  - Without mem_ack: remain in REQ.
  - mem_ack=1 and branch_en=0: instr<=mem_rdata, pc<=pc+1 (wrap), -> ISSUE.
  - mem_ack=1 and branch_en=1: fetched word discarded, pc<=branch_target, stay REQ (new request next cycle).
  - branch_en=1 without ack: pc<=branch_target, stay REQ. The request address changes next cycle; the memory must tolerate this.
- ISSUE:
  - instr_valid=1; instr, opcode and imm9 stable.
  - stall=1: hold all outputs.
  - stall=0: instruction consumed, -> REQ next cycle. instr_valid drops unless a new word is latched.
  - branch_en=1 (overrides stall): instr_valid<=0, pc<=branch_target, -> REQ.
- Latency:
  - start in cycle N -> mem_req=1 in N+1.
  - mem_ack in cycle K -> instr_valid=1 in K+1.
  - Zero-wait memory, no stall: one instruction every 2 cycles.
- pc wrap: pc=2^ADDR_W-1 fetched -> pc=0.
- All outputs registered. opcode and imm9 are slices of the registered instr.

Optional Feature:
- Macro IFR_HALT_DETECT_EN.
- Defined: a latched opcode of 7'h7F enters HALTED after ISSUE consumption (stall=0). In HALTED:
  - halted=1, mem_req=0, instr_valid=0.
  - Only reset exits; branch_en and start are ignored.
- Undefined: 7'h7F is an ordinary opcode; halted is tied 0; no HALTED state.

Decomposition:
- Package ifr_pkg:
  - state enum (IDLE, REQ, ISSUE, HALTED).
  - OPC_W=7, IMM_W=9, INSTR_W=16, HALT_OPC=7'h7F.
- One natural sub-module, ifr_pc_reg: PC register with load (branch), increment-with-wrap, and async reset to RESET_PC.
- The FSM and instruction latch stay in the top module.

Test Plan:
- Reset then start, zero-wait memory returning 16'hFE0C at addr 0 -> mem_req at cycle 1; instr_valid=1 next cycle with opcode=7'h7F (feature off), imm9=9'h00C; pc=1.
- Memory acks after 3 wait cycles -> mem_req held 3 cycles at mem_addr=pc; instr_valid=1 exactly one cycle after ack.
- stall=1 for 4 cycles in ISSUE with instr=16'h0114 -> instr, imm9=9'h114, instr_valid constant; mem_req stays 0; resumes REQ one cycle after stall drops.
- branch_en with branch_target=10'h155 coincident with mem_ack -> word discarded, instr_valid stays 0, next mem_addr=10'h155.
- pc=10'h3FF fetch -> pc=0 afterwards. Also: rst_n asserted mid-REQ -> mem_req and instr_valid drop immediately, pc=RESET_PC.
- IFR_HALT_DETECT_EN defined, fetch 16'hFE00 -> halted=1 after consumption, no further mem_req, start ignored until reset.

Source files
------------

// File: rtl/ifr_pkg.sv
// Shared definitions for the instruction fetch register.
// Contents: fetch FSM state enum, instruction field widths and the halt opcode.
package ifr_pkg;

  localparam int OPC_W   = 7;
  localparam int IMM_W   = 9;
  localparam int INSTR_W = 16;

  localparam logic [OPC_W-1:0] HALT_OPC = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } ifr_state_e;

endpackage

// File: rtl/ifr_pc_reg.sv
// Program counter register for the fetch stage.
// Ports:
//   clk, rst_n   clock, async active-low reset (loads RESET_PC)
//   load         take load_val as the new PC (branch); wins over inc
//   load_val     branch target
//   inc          advance PC by one, wrapping modulo 2^ADDR_W
//   pc           current PC
module ifr_pc_reg #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      // Natural overflow of the ADDR_W-bit sum gives the wrap to 0.
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_reg.sv
// Fetch stage feeding the 9-bit sign-extension stage. Requests 16-bit words
// over a req/ack handshake, latches them and splits opcode / imm9.
// Optional halt detection is enabled with the macro IFR_HALT_DETECT_EN.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   start                          leave IDLE and begin fetching
//   stall                          downstream not ready, hold instruction
//   branch_en, branch_target       PC redirect (priority over sequencing)
//   mem_req, mem_addr              registered fetch request / address (= pc)
//   mem_ack, mem_rdata             memory response
//   instr_valid, instr             latched instruction and its valid flag
//   opcode, imm9                   instr[15:9], instr[8:0]
//   pc                             address of the next fetch
//   busy                           state != IDLE
//   halted                         halt opcode consumed (0 without the feature)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start; branch_en still loads pc
// ST_REQ    | mem_req high at mem_addr=pc, waiting for mem_ack
// ST_ISSUE  | instruction valid, held while stall=1
// ST_HALTED | halt opcode consumed; only reset leaves (feature builds only)
module instr_fetch_reg
  import ifr_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode,
  output logic [IMM_W-1:0]   imm9,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted
);

  ifr_state_e         state_d, state_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic               mem_req_d, mem_req_q;
  logic               instr_valid_d, instr_valid_q;
  logic               busy_d, busy_q;
  logic               pc_load;
  logic               pc_inc;

  ifr_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (branch_target),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (branch_en) begin
          pc_load = 1'b1;
        end
        if (start) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A branch coincident with ack drops the returned word.
        if (branch_en) begin
          pc_load = 1'b1;
        end else if (mem_ack) begin
          instr_d = mem_rdata;
          pc_inc  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (branch_en) begin
          pc_load = 1'b1;
          state_d = ST_REQ;
        end else if (!stall) begin
`ifdef IFR_HALT_DETECT_EN
          if (instr_q[INSTR_W-1 -: OPC_W] == HALT_OPC) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_REQ;
          end
`else
          state_d = ST_REQ;
`endif
        end
      end
`ifdef IFR_HALT_DETECT_EN
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they register in step with it.
    mem_req_d     = (state_d == ST_REQ);
    instr_valid_d = (state_d == ST_ISSUE);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      mem_req_q     <= mem_req_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
    end
  end

`ifdef IFR_HALT_DETECT_EN
  logic halted_d, halted_q;

  assign halted_d = (state_d == ST_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[INSTR_W-1 -: OPC_W];
  assign imm9        = instr_q[IMM_W-1:0];
  assign busy        = busy_q;

endmodule

// File: tb/tb_instr_fetch_reg.sv
module tb_instr_fetch_reg;

  localparam int ADDR_W = 10;
  localparam int PC_MOD = 1 << ADDR_W;
  localparam int RESET_PC = 0;
`ifdef IFR_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stall = 1'b0;
  logic              branch_en = 1'b0;
  logic [ADDR_W-1:0] branch_target = '0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [15:0]       mem_rdata;
  logic              instr_valid;
  logic [15:0]       instr;
  logic [6:0]        opcode;
  logic [8:0]        imm9;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;

  logic [15:0] mem_arr [0:PC_MOD-1];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_arr[mem_addr];

  instr_fetch_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (ADDR_W'(RESET_PC))
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .opcode        (opcode),
    .imm9          (imm9),
    .pc            (pc),
    .busy          (busy),
    .halted        (halted)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: what the fetch stage is doing, as a plain activity mode.
  localparam int M_IDLE = 0;  // not fetching
  localparam int M_WAIT = 1;  // request outstanding
  localparam int M_HOLD = 2;  // presenting an instruction
  localparam int M_STOP = 3;  // halted
  int          m_mode = M_IDLE;
  int          m_pc   = RESET_PC;
  logic [15:0] m_instr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  = M_IDLE;
      m_pc    = RESET_PC;
      m_instr = '0;
    end else begin
      if (m_mode == M_IDLE) begin
        if (branch_en) m_pc = int'(branch_target);
        if (start) m_mode = M_WAIT;
      end else if (m_mode == M_WAIT) begin
        if (branch_en) begin
          m_pc = int'(branch_target);
        end else if (mem_ack) begin
          m_instr = mem_arr[m_pc];
          m_pc    = (m_pc + 1) % PC_MOD;
          m_mode  = M_HOLD;
        end
      end else if (m_mode == M_HOLD) begin
        if (branch_en) begin
          m_pc   = int'(branch_target);
          m_mode = M_WAIT;
        end else if (!stall) begin
          m_mode = (HALT_EN && (m_instr >> 9) == 16'h7F) ? M_STOP : M_WAIT;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_mem_req", {31'd0, mem_req}, {31'd0, m_mode == M_WAIT});
    chk("model_instr_valid", {31'd0, instr_valid}, {31'd0, m_mode == M_HOLD});
    chk("model_busy", {31'd0, busy}, {31'd0, m_mode != M_IDLE});
    chk("model_halted", {31'd0, halted}, {31'd0, m_mode == M_STOP});
    chk("model_pc", 32'(pc), 32'(m_pc));
    chk("model_instr", 32'(instr), 32'(m_instr));
    chk("model_opcode", 32'(opcode), 32'(m_instr / 512));
    chk("model_imm9", 32'(imm9), 32'(m_instr % 512));
    if (m_mode == M_WAIT) chk("model_mem_addr", 32'(mem_addr), 32'(m_pc));
  end

  // Advance to the drive point: 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < PC_MOD; i++) mem_arr[i] = 16'h0000;
    mem_arr[0]       = 16'hFE0C;
    mem_arr[1]       = 16'h0114;
    mem_arr[PC_MOD-1] = 16'h1234;

    step();
    chk("rst_pc", 32'(pc), 32'(RESET_PC));
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // Start with zero-wait memory.
    rst_n = 1'b1;
    start = 1'b1;
    step();
    chk("start_mem_req", {31'd0, mem_req}, 32'd1);
    chk("start_mem_addr", 32'(mem_addr), 32'd0);
    start   = 1'b0;
    mem_ack = 1'b1;
    step();
    chk("fe0c_valid", {31'd0, instr_valid}, 32'd1);
    chk("fe0c_opcode", 32'(opcode), 32'h7F);
    chk("fe0c_imm9", 32'(imm9), 32'h00C);
    chk("fe0c_pc", 32'(pc), 32'd1);
    mem_ack = 1'b0;
    stall   = 1'b0;
    step();
    if (HALT_EN) begin
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_no_req", {31'd0, mem_req}, 32'd0);
      start         = 1'b1;
      branch_en     = 1'b1;
      branch_target = 10'h005;
      for (int i = 0; i < 3; i++) begin
        step();
        chk("halt_hold", {31'd0, halted}, 32'd1);
        chk("halt_hold_req", {31'd0, mem_req}, 32'd0);
        chk("halt_hold_pc", 32'(pc), 32'd1);
      end
      start     = 1'b0;
      branch_en = 1'b0;
    end else begin
      chk("consume_req", {31'd0, mem_req}, 32'd1);
      chk("consume_addr", 32'(mem_addr), 32'd1);
      chk("consume_halted", {31'd0, halted}, 32'd0);
    end

    rst_n = 1'b0;
    #1;
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    step();
    rst_n = 1'b1;

    // Branch while idle, then a fetch with three wait cycles.
    branch_en     = 1'b1;
    branch_target = 10'h001;
    step();
    chk("idle_branch_pc", 32'(pc), 32'd1);
    chk("idle_branch_busy", {31'd0, busy}, 32'd0);
    branch_en = 1'b0;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", {31'd0, mem_req}, 32'd1);
      chk("wait_addr", 32'(mem_addr), 32'd1);
      step();
    end
    chk("wait_req_last", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    step();
    chk("wait_valid", {31'd0, instr_valid}, 32'd1);
    chk("wait_instr", 32'(instr), 32'h0114);
    chk("wait_imm9", 32'(imm9), 32'h114);

    // Hold under stall.
    mem_ack = 1'b0;
    stall   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", 32'(instr), 32'h0114);
      chk("stall_imm9", 32'(imm9), 32'h114);
      chk("stall_no_req", {31'd0, mem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    chk("resume_req", {31'd0, mem_req}, 32'd1);
    chk("resume_valid", {31'd0, instr_valid}, 32'd0);
    chk("resume_addr", 32'(mem_addr), 32'd2);

    // Branch coincident with ack discards the word.
    mem_ack       = 1'b1;
    branch_en     = 1'b1;
    branch_target = 10'h155;
    step();
    chk("br_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("br_ack_req", {31'd0, mem_req}, 32'd1);
    chk("br_ack_addr", 32'(mem_addr), 32'h155);

    // PC wrap.
    mem_ack       = 1'b0;
    branch_target = 10'h3FF;
    step();
    chk("wrap_addr", 32'(mem_addr), 32'h3FF);
    branch_en = 1'b0;
    mem_ack   = 1'b1;
    step();
    chk("wrap_pc", 32'(pc), 32'd0);
    chk("wrap_instr", 32'(instr), 32'h1234);
    mem_ack = 1'b0;
    step();
    chk("midreq_req", {31'd0, mem_req}, 32'd1);

    // Reset in the middle of a request.
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_pc", 32'(pc), 32'(RESET_PC));
    step();
    rst_n   = 1'b1;
    mem_ack = 1'b1;
    step();
    chk("late_ack_busy", {31'd0, busy}, 32'd0);
    chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    mem_ack = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < PC_MOD; i++) mem_arr[i] = 16'($urandom);
    for (int cyc = 0; cyc < 6000; cyc++) begin
      rst_n         = ($urandom_range(0, 299) != 0);
      start         = ($urandom_range(0, 3) == 0);
      stall         = ($urandom_range(0, 2) == 0);
      branch_en     = ($urandom_range(0, 11) == 0);
      branch_target = ADDR_W'($urandom);
      mem_ack       = (mem_req || !busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      if ($urandom_range(0, 63) == 0) mem_arr[$urandom_range(0, PC_MOD-1)] = 16'($urandom);
      step();
    end

    rst_n = 1'b1;
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
